// File: rtl/sseg_pkg.sv
// Shared types and constants for the seven-segment display path.
// Segment patterns are active-low: bit7 = dp, bits 6:0 = g..a.
package sseg_pkg;

  typedef logic [7:0] seg_pattern_t;

  localparam int NUM_DIGITS = 4;
  localparam seg_pattern_t SSEG_OFF = 8'hFF;

  localparam seg_pattern_t GLYPH_H = 8'b10001001;
  localparam seg_pattern_t GLYPH_I = 8'b11111001;

  localparam seg_pattern_t GLYPH_HEX [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // One-hot-low anode enable for the selected digit.
  function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [$clog2(NUM_DIGITS)-1:0] idx);
    logic [NUM_DIGITS-1:0] a;
    a = '1;
    a[idx] = 1'b0;
    return a;
  endfunction

endpackage

// File: rtl/sseg_refresh_counter.sv
// Free-running refresh counter: splits the count into digit index and PWM phase
// and flags the last cycle of each frame.
module sseg_refresh_counter
  import sseg_pkg::*;
#(
  parameter int N = 18
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [N-1:0]                  q,
  output logic [$clog2(NUM_DIGITS)-1:0] idx,
  output logic [3:0]                    ph,
  output logic                          wrap
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= q + N'(1);
    end
  end

  assign idx  = q[N-1:N-2];
  assign ph   = q[N-3:N-6];
  assign wrap = &q;

endmodule

// File: rtl/sseg_scan_driver.sv
// Four-digit multiplexed seven-segment scanner with per-slot PWM dimming and
// frame-aligned shadow capture of the digit patterns.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int N = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic [3:0] bright,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  logic [N-1:0]                  q_p0;
  logic [$clog2(NUM_DIGITS)-1:0] idx_p0;
  logic [3:0]                    ph_p0;
  logic                          wrap_p0;
  logic                          load_p0;
  logic                          lit_p0;

  seg_pattern_t sh [NUM_DIGITS];

  logic [3:0]   an_p1;
  seg_pattern_t sseg_p1;
  logic         tick_p1;

  sseg_refresh_counter #(.N(N)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .q     (q_p0),
    .idx   (idx_p0),
    .ph    (ph_p0),
    .wrap  (wrap_p0)
  );

  // Stage p0: counter state and brightness decide what the next output shows.
  // The shadow load fires on the all-ones count, the same cycle as wrap.
  assign load_p0 = (q_p0 == {N{1'b1}});
  assign lit_p0  = (ph_p0 <= bright);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        sh[d] <= SSEG_OFF;
      end
    end else if (load_p0) begin
      sh[0] <= in0;
      sh[1] <= in1;
      sh[2] <= in2;
      sh[3] <= in3;
    end
  end

  // Stage p1: registered pin drive; segments always blanked with anodes off.
  always_ff @(posedge clk) begin
    if (reset) begin
      an_p1   <= 4'b1111;
      sseg_p1 <= SSEG_OFF;
      tick_p1 <= 1'b0;
    end else begin
      an_p1   <= lit_p0 ? anode_sel(idx_p0) : 4'b1111;
      sseg_p1 <= lit_p0 ? sh[idx_p0] : SSEG_OFF;
      tick_p1 <= wrap_p0;
    end
  end

  assign an         = an_p1;
  assign sseg       = sseg_p1;
  assign frame_tick = tick_p1;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver at N=8: cycle-level reference model plus directed
// scenarios with literal expectations.
module tb_sseg_scan_driver;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in0, in1, in2, in3;
  logic [3:0] bright;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       frame_tick;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  sseg_scan_driver #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in0        (in0),
    .in1        (in1),
    .in2        (in2),
    .in3        (in3),
    .bright     (bright),
    .an         (an),
    .sseg       (sseg),
    .frame_tick (frame_tick)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: k counts clock edges since reset release; position in
  // frame, digit slot and PWM phase follow from plain arithmetic on k.
  int         k;
  int         pos, dig, phase;
  logic       model_ok = 1'b0;
  logic [3:0] m_an;
  logic [7:0] m_sseg;
  logic       m_ft;
  logic [7:0] msh [4];

  always @(posedge clk) begin
    if (reset) begin
      k = 0;
      m_an = 4'hF;
      m_sseg = 8'hFF;
      m_ft = 1'b0;
      for (int d = 0; d < 4; d++) msh[d] = 8'hFF;
      model_ok = 1'b1;
    end else if (model_ok) begin
      pos   = k % 256;
      dig   = pos / 64;
      phase = (pos % 64) / 4;
      if (phase <= int'(bright)) begin
        m_an = 4'hF;
        m_an[dig] = 1'b0;
        m_sseg = msh[dig];
      end else begin
        m_an = 4'hF;
        m_sseg = 8'hFF;
      end
      m_ft = (pos == 255);
      if (pos == 255) begin
        msh[0] = in0; msh[1] = in1; msh[2] = in2; msh[3] = in3;
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      chk("model_an", 32'(an), 32'(m_an));
      chk("model_sseg", 32'(sseg), 32'(m_sseg));
      chk("model_tick", 32'(frame_tick), 32'(m_ft));
    end
  end

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 600);
    if (frame_tick !== 1'b1) begin
      nvec++;
      nmis++;
      $display("FAIL tick_timeout: no frame_tick within %0d cycles", n);
    end
  endtask

  logic [3:0] an_tbl [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
  logic [7:0] sg_tbl [4] = '{8'hF9, 8'h89, 8'hFF, 8'hFF};
  int         lit [4];
  int         n, cnt;

  initial begin
    reset = 1'b1;
    in0 = 8'hFF; in1 = 8'hFF; in2 = 8'hFF; in3 = 8'hFF;
    bright = 4'hF;

    repeat (3) begin
      @(negedge clk);
      chk("rst_an", 32'(an), 32'h0000_000F);
      chk("rst_sseg", 32'(sseg), 32'h0000_00FF);
      chk("rst_tick", 32'(frame_tick), 32'h0);
    end
    in0 = 8'hF9; in1 = 8'h89;
    reset = 1'b0;

    @(negedge clk);
    chk("first_an", 32'(an), 32'h0000_000E);
    chk("first_sseg", 32'(sseg), 32'h0000_00FF);

    wait_tick(n);
    chk("first_tick_gap", 32'(n), 32'd255);

    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      chk("scan_an", 32'(an), 32'(an_tbl[i/64]));
      chk("scan_sseg", 32'(sseg), 32'(sg_tbl[i/64]));
      chk("scan_tick", 32'(frame_tick), 32'(i == 255));
    end

    bright = 4'h3;
    for (int d = 0; d < 4; d++) lit[d] = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (an != 4'hF) lit[i/64]++;
    end
    for (int d = 0; d < 4; d++) chk("dim3_lit", 32'(lit[d]), 32'd16);

    bright = 4'h0;
    for (int d = 0; d < 4; d++) lit[d] = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (an != 4'hF) lit[i/64]++;
    end
    for (int d = 0; d < 4; d++) chk("dim0_lit", 32'(lit[d]), 32'd4);

    bright = 4'hF;
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (an == 4'hE && sseg == 8'hF9) cnt++;
      if (i == 39) in0 = 8'hC0;
    end
    chk("tearfree_old_cycles", 32'(cnt), 32'd64);
    chk("tearfree_tick", 32'(frame_tick), 32'h1);
    @(negedge clk);
    chk("tearfree_new_an", 32'(an), 32'h0000_000E);
    chk("tearfree_new_sseg", 32'(sseg), 32'h0000_00C0);

    wait_tick(n);
    chk("cadence_first", 32'(n), 32'd255);
    for (int f = 0; f < 4; f++) begin
      wait_tick(n);
      chk("cadence_gap", 32'(n), 32'd256);
    end

    repeat (150) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_an", 32'(an), 32'h0000_000F);
    chk("midrst_sseg", 32'(sseg), 32'h0000_00FF);
    chk("midrst_tick", 32'(frame_tick), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_restart_an", 32'(an), 32'h0000_000E);
    chk("midrst_restart_sseg", 32'(sseg), 32'h0000_00FF);
    wait_tick(n);
    chk("midrst_tick_gap", 32'(n), 32'd255);
    @(negedge clk);
    chk("midrst_content", 32'(sseg), 32'h0000_00C0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
